// File: rtl/id_ring_tracker_if.sv
// id_ring_tracker_if
//   Bundles the issue, writeback and retire signals of the ID ring tracker.
//   Parameters must match those of the id_ring_tracker instance it connects to.
//   slave modport  : tracker side (takes requests, drives grants/retire/status)
//   master modport : issue/commit side (drives requests, observes the tracker)
//   Signals:
//     flush, alloc_req, wb_valid, wb_id       -> tracker
//     alloc_ack, alloc_id, retire,
//     inflight_count, empty, full             <- tracker
interface id_ring_tracker_if #(
  parameter int MAX_IDS      = 8,
  parameter int RETIRE_PORTS = 2
);
  localparam int ID_W  = $clog2(MAX_IDS);
  localparam int CNT_W = $clog2(RETIRE_PORTS + 1);

  typedef logic [ID_W-1:0] id_t;

  typedef struct packed {
    logic             valid;
    id_t              phys_id;
    logic [CNT_W-1:0] count;
  } retire_packet_t;

  logic           flush;
  logic           alloc_req;
  logic           alloc_ack;
  id_t            alloc_id;
  logic           wb_valid;
  id_t            wb_id;
  retire_packet_t retire;
  logic [ID_W:0]  inflight_count;
  logic           empty;
  logic           full;

  modport slave (
    input  flush, alloc_req, wb_valid, wb_id,
    output alloc_ack, alloc_id, retire, inflight_count, empty, full
  );

  modport master (
    output flush, alloc_req, wb_valid, wb_id,
    input  alloc_ack, alloc_id, retire, inflight_count, empty, full
  );
endinterface

// File: rtl/id_ring_tracker.sv
// id_ring_tracker
//   Circular allocator for in-flight instruction IDs. IDs are granted in ring
//   order at the tail, marked done by writeback in any order, and retired in
//   order from the head, up to RETIRE_PORTS per cycle.
//   Ports:
//     clk  : sole clock, rising edge
//     rst  : synchronous active-high reset (behaves like flush, highest priority)
//     bus  : id_ring_tracker_if.slave (flush, alloc, writeback, retire, status)
module id_ring_tracker #(
  parameter int MAX_IDS      = 8,
  parameter int RETIRE_PORTS = 2
) (
  input logic               clk,
  input logic               rst,
  id_ring_tracker_if.slave  bus
);
  localparam int ID_W  = $clog2(MAX_IDS);
  localparam int PTR_W = ID_W + 1;
  localparam int CNT_W = $clog2(RETIRE_PORTS + 1);

  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [PTR_W-1:0]   count_q, count_d;
  logic [MAX_IDS-1:0] done_q, done_d;

  logic               full_w;
  logic               alloc_ack_w;
  logic [ID_W-1:0]    head_idx;
  logic [ID_W-1:0]    tail_idx;
  logic [ID_W-1:0]    wb_offset;
  logic               wb_hit;
  logic [CNT_W-1:0]   ret_cnt;

  assign head_idx = head_q[ID_W-1:0];
  assign tail_idx = tail_q[ID_W-1:0];
  assign full_w   = (count_q == PTR_W'(MAX_IDS));

  // Full is judged on the registered count, so a retire in this same cycle
  // cannot open a slot for allocation until the next cycle.
  assign alloc_ack_w = bus.alloc_req & ~full_w & ~bus.flush & ~rst;

  // An ID is in flight when its ring distance from head is below the count.
  assign wb_offset = bus.wb_id - head_idx;
  assign wb_hit    = bus.wb_valid && ({1'b0, wb_offset} < count_q);

  // Retire group: run of consecutive done slots starting at head, stopping at
  // the first not-done slot, the port limit, or the in-flight count.
  always_comb begin
    logic            run;
    logic [ID_W-1:0] slot;
    ret_cnt = '0;
    run     = 1'b1;
    slot    = '0;
    for (int i = 0; i < RETIRE_PORTS; i++) begin
      slot = head_idx + ID_W'(i);
      if (run && done_q[slot] && (PTR_W'(i) < count_q)) begin
        ret_cnt = ret_cnt + CNT_W'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    done_d  = done_q;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      done_d  = '0;
    end else begin
      head_d  = head_q + PTR_W'(ret_cnt);
      tail_d  = tail_q + PTR_W'(alloc_ack_w);
      count_d = count_q + PTR_W'(alloc_ack_w) - PTR_W'(ret_cnt);
      // Order matters: a duplicate writeback to a slot retiring this cycle
      // must not leave a stale done bit behind, so the retire clear wins.
      if (wb_hit) begin
        done_d[bus.wb_id] = 1'b1;
      end
      for (int i = 0; i < RETIRE_PORTS; i++) begin
        if (CNT_W'(i) < ret_cnt) begin
          done_d[head_idx + ID_W'(i)] = 1'b0;
        end
      end
      if (alloc_ack_w) begin
        done_d[tail_idx] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign bus.alloc_ack      = alloc_ack_w;
  assign bus.alloc_id       = tail_idx;
  assign bus.retire         = {(ret_cnt != '0), head_idx, ret_cnt};
  assign bus.inflight_count = count_q;
  assign bus.empty          = (count_q == '0);
  assign bus.full           = full_w;
endmodule

// File: tb/tb_id_ring_tracker.sv
module tb_id_ring_tracker;
  localparam int MAX_IDS      = 8;
  localparam int RETIRE_PORTS = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  id_ring_tracker_if #(.MAX_IDS(MAX_IDS), .RETIRE_PORTS(RETIRE_PORTS)) ifc ();

  id_ring_tracker #(.MAX_IDS(MAX_IDS), .RETIRE_PORTS(RETIRE_PORTS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    ifc.flush     = 1'b0;
    ifc.alloc_req = 1'b0;
    ifc.wb_valid  = 1'b0;
    ifc.wb_id     = '0;
  endtask

  task automatic wb(input int id);
    ifc.wb_valid = 1'b1;
    ifc.wb_id    = 3'(id);
    tick();
    ifc.wb_valid = 1'b0;
  endtask

  task automatic alloc_n(input int n);
    ifc.alloc_req = 1'b1;
    repeat (n) tick();
    ifc.alloc_req = 1'b0;
  endtask

  initial begin
    // Reset with alloc_req asserted: no grant, clean state
    rst = 1'b1;
    idle_inputs();
    ifc.alloc_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alloc_ack", ifc.alloc_ack, 0);
    chk("rst_empty", ifc.empty, 1);
    chk("rst_full", ifc.full, 0);
    chk("rst_count", ifc.inflight_count, 0);
    chk("rst_retire_valid", ifc.retire.valid, 0);
    chk("rst_alloc_id", ifc.alloc_id, 0);
    rst = 1'b0;
    ifc.alloc_req = 1'b0;
    tick();

    // Fill: 10 cycles of requests, only 8 granted
    ifc.alloc_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      settle();
      chk($sformatf("fill_ack_%0d", k), ifc.alloc_ack, (k < 8) ? 1 : 0);
      if (k < 8) chk($sformatf("fill_id_%0d", k), ifc.alloc_id, k);
      tick();
      if (k == 7) chk("fill_full_after_8", ifc.full, 1);
    end
    ifc.alloc_req = 1'b0;
    chk("fill_count", ifc.inflight_count, 8);

    // Full ring: wb 0, then retire 1 while alloc is still blocked
    wb(0);
    ifc.alloc_req = 1'b1;
    settle();
    chk("sim_retire_valid", ifc.retire.valid, 1);
    chk("sim_retire_id", ifc.retire.phys_id, 0);
    chk("sim_retire_cnt", ifc.retire.count, 1);
    chk("sim_ack_blocked", ifc.alloc_ack, 0);
    tick();
    chk("sim_ack_next", ifc.alloc_ack, 1);
    chk("sim_id_next", ifc.alloc_id, 0);
    tick();
    ifc.alloc_req = 1'b0;
    chk("sim_count_refull", ifc.inflight_count, 8);

    // Drain IDs 1..6 one per cycle, leaving head at 7 with 7 and 0 in flight
    for (int k = 1; k <= 6; k++) wb(k);
    tick();
    chk("wrap_pre_count", ifc.inflight_count, 2);
    chk("wrap_pre_head", ifc.retire.phys_id, 7);
    chk("wrap_pre_valid", ifc.retire.valid, 0);
    wb(0);
    ifc.wb_valid = 1'b1;
    ifc.wb_id    = 3'd7;
    settle();
    chk("wrap_no_retire_yet", ifc.retire.valid, 0);
    tick();
    ifc.wb_valid = 1'b0;
    chk("wrap_retire_valid", ifc.retire.valid, 1);
    chk("wrap_retire_id", ifc.retire.phys_id, 7);
    chk("wrap_retire_cnt", ifc.retire.count, 2);
    tick();
    chk("wrap_count_after", ifc.inflight_count, 0);
    chk("wrap_empty_after", ifc.empty, 1);
    chk("wrap_head_after", ifc.retire.phys_id, 1);
    chk("wrap_alloc_id_after", ifc.alloc_id, 1);

    // Out-of-order writeback: IDs 0..3, wb 2, 1, 0
    ifc.flush = 1'b1;
    tick();
    ifc.flush = 1'b0;
    chk("ooo_flush_empty", ifc.empty, 1);
    alloc_n(4);
    chk("ooo_count", ifc.inflight_count, 4);
    ifc.wb_valid = 1'b1;
    ifc.wb_id = 3'd2; settle(); chk("ooo_nr_wb2", ifc.retire.valid, 0); tick();
    ifc.wb_id = 3'd1; settle(); chk("ooo_nr_wb1", ifc.retire.valid, 0); tick();
    ifc.wb_id = 3'd0; settle(); chk("ooo_nr_wb0", ifc.retire.valid, 0); tick();
    ifc.wb_valid = 1'b0;
    settle();
    chk("ooo_r1_valid", ifc.retire.valid, 1);
    chk("ooo_r1_id", ifc.retire.phys_id, 0);
    chk("ooo_r1_cnt", ifc.retire.count, 2);
    tick();
    chk("ooo_r2_valid", ifc.retire.valid, 1);
    chk("ooo_r2_id", ifc.retire.phys_id, 2);
    chk("ooo_r2_cnt", ifc.retire.count, 1);
    tick();
    chk("ooo_r3_valid", ifc.retire.valid, 0);
    chk("ooo_r3_cnt", ifc.retire.count, 0);
    chk("ooo_id3_inflight", ifc.inflight_count, 1);
    chk("ooo_head3", ifc.retire.phys_id, 3);

    // Stray writeback to ID 5 while only 0..2 are in flight
    ifc.flush = 1'b1;
    tick();
    ifc.flush = 1'b0;
    alloc_n(3);
    wb(5);
    chk("stray_count", ifc.inflight_count, 3);
    chk("stray_no_retire", ifc.retire.valid, 0);
    alloc_n(3);
    chk("stray_count6", ifc.inflight_count, 6);
    for (int k = 0; k <= 4; k++) wb(k);
    tick();
    chk("stray_id5_not_done", ifc.inflight_count, 1);
    chk("stray_head5", ifc.retire.phys_id, 5);
    chk("stray_valid5", ifc.retire.valid, 0);

    // Duplicate writeback of ID 5
    wb(5);
    ifc.wb_valid = 1'b1;
    ifc.wb_id    = 3'd5;
    settle();
    chk("dup_retire_cnt", ifc.retire.count, 1);
    tick();
    ifc.wb_valid = 1'b0;
    chk("dup_count", ifc.inflight_count, 0);
    chk("dup_empty", ifc.empty, 1);
    chk("dup_no_retire", ifc.retire.valid, 0);

    // Flush with 5 in flight, alloc and wb in the same cycle
    alloc_n(5);
    wb(6);
    chk("flush_pre_count", ifc.inflight_count, 5);
    ifc.flush     = 1'b1;
    ifc.alloc_req = 1'b1;
    ifc.wb_valid  = 1'b1;
    ifc.wb_id     = 3'd7;
    settle();
    chk("flush_ack", ifc.alloc_ack, 0);
    chk("flush_retire_valid", ifc.retire.valid, 1);
    chk("flush_retire_id", ifc.retire.phys_id, 6);
    tick();
    idle_inputs();
    settle();
    chk("flush_empty", ifc.empty, 1);
    chk("flush_count", ifc.inflight_count, 0);
    chk("flush_alloc_id", ifc.alloc_id, 0);
    chk("flush_retire_after", ifc.retire.valid, 0);

    // Reset mid-operation
    alloc_n(2);
    rst = 1'b1;
    ifc.alloc_req = 1'b1;
    settle();
    chk("mrst_ack", ifc.alloc_ack, 0);
    tick();
    rst = 1'b0;
    ifc.alloc_req = 1'b0;
    settle();
    chk("mrst_empty", ifc.empty, 1);
    chk("mrst_count", ifc.inflight_count, 0);
    chk("mrst_full", ifc.full, 0);
    chk("mrst_alloc_id", ifc.alloc_id, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
